// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        RDATA = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core port, debug port and memory-side signals of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
) ();

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_wen;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: serves both requesters and drives the memory.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_wen, mem_ren, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory side as seen from outside the arbiter.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_wen, mem_ren, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select: one-hot grant {dbg, core} from the request bits and preferred requester.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = (ptr_i == REQ_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-ported unified memory; define MEM_ARB_RR_EN for round-robin,
// otherwise the core has fixed priority over the debug port.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e state_q, state_d;
    req_id_e    owner_q, owner_d;
    req_id_e    ptr;
    logic [1:0] req_v;
    logic [1:0] gnt_v;

`ifdef MEM_ARB_RR_EN
    req_id_e ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= REQ_CORE;
        else      ptr_q <= ptr_d;
    end

    // After a grant the requester that lost (or was absent) becomes preferred.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_v[0])      ptr_d = REQ_DBG;
        else if (gnt_v[1]) ptr_d = REQ_CORE;
    end

    assign ptr = ptr_q;
`else
    assign ptr = REQ_CORE;
`endif

    // Gating with rst keeps grants and enables low for the whole reset window.
    assign req_v = (state_q == IDLE && rst) ? {bus.dbg_req, bus.core_req} : 2'b00;

    arb_pick u_pick (
        .req_i (req_v),
        .ptr_i (ptr),
        .gnt_o (gnt_v)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= REQ_CORE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        bus.core_gnt    = gnt_v[0];
        bus.dbg_gnt     = gnt_v[1];
        bus.core_rvalid = 1'b0;
        bus.core_rdata  = '0;
        bus.dbg_rvalid  = 1'b0;
        bus.dbg_rdata   = '0;
        bus.mem_wen     = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (gnt_v[1]) begin
                    bus.mem_addr  = bus.dbg_addr;
                    bus.mem_wdata = bus.dbg_wdata;
                    if (bus.dbg_we) begin
                        bus.mem_wen = 1'b1;
                    end else begin
                        bus.mem_ren = 1'b1;
                        owner_d     = REQ_DBG;
                        state_d     = RDATA;
                    end
                end else if (gnt_v[0]) begin
                    bus.mem_addr  = bus.core_addr;
                    bus.mem_wdata = bus.core_wdata;
                    if (bus.core_we) begin
                        bus.mem_wen = 1'b1;
                    end else begin
                        bus.mem_ren = 1'b1;
                        owner_d     = REQ_CORE;
                        state_d     = RDATA;
                    end
                end
            end
            RDATA: begin
                if (owner_q == REQ_DBG) begin
                    bus.dbg_rvalid = 1'b1;
                    bus.dbg_rdata  = bus.mem_rdata;
                end else begin
                    bus.core_rvalid = 1'b1;
                    bus.core_rdata  = bus.mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected read returns plus per-scenario grant checks.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port memory with one-cycle read latency.
    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd_q = 32'h0;
    assign bus.mem_rdata = rd_q;

    always @(posedge clk) begin
        if (bus.mem_wen) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_ren) rd_q <= mem_arr[bus.mem_addr[7:0]];
    end

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        req_id_e     id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Read-return monitor: pops the scoreboard whenever either port shows rvalid.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.core_rvalid && bus.dbg_rvalid) begin
                vectors++;
                miscompares++;
                $display("FAIL both_rvalid: got core=1 dbg=1, expected at most one");
            end else if (bus.core_rvalid || bus.dbg_rvalid) begin
                req_id_e     id;
                logic [31:0] d;
                id = bus.core_rvalid ? REQ_CORE : REQ_DBG;
                d  = bus.core_rvalid ? bus.core_rdata : bus.dbg_rdata;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rvalid: got id=%0d data=%h at cycle %0d, expected no rvalid", id, d, cycle);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.id !== id || e.data !== d || cycle !== e.cyc + 1) begin
                        miscompares++;
                        $display("FAIL read_return: got id=%0d data=%h cycle=%0d, expected id=%0d data=%h cycle=%0d",
                                 id, d, cycle, e.id, e.data, e.cyc + 1);
                    end else begin
                        $display("read return id=%0d data=%h cycle=%0d ok", id, d, cycle);
                    end
                end
            end
            vectors++;
            if ((!bus.core_rvalid && bus.core_rdata !== 32'h0) || (!bus.dbg_rvalid && bus.dbg_rdata !== 32'h0)) begin
                miscompares++;
                $display("FAIL idle_rdata: got core_rdata=%h dbg_rdata=%h, expected 0 when not valid",
                         bus.core_rdata, bus.dbg_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
    endtask

    task automatic apply_reset();
        tick();
        clear_reqs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.core_req = 1'b1; bus.dbg_req = 1'b1;
        #1;
        vectors++;
        if ({bus.core_gnt, bus.dbg_gnt, bus.mem_wen, bus.mem_ren} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt/gnt/wen/ren=%b, expected 0000",
                     {bus.core_gnt, bus.dbg_gnt, bus.mem_wen, bus.mem_ren});
        end
        clear_reqs();
        tick();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.core_gnt, bus.dbg_gnt, bus.mem_wen, bus.mem_ren} !== 4'b0000 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL idle_no_req: got en=%b addr=%h wdata=%h, expected all 0",
                     {bus.core_gnt, bus.dbg_gnt, bus.mem_wen, bus.mem_ren}, bus.mem_addr, bus.mem_wdata);
        end
        $display("reset check done");
    endtask

    task automatic test_write();
        tick();
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 16'h0010; bus.core_wdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if (bus.core_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0 || bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0 ||
            bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL core_write: got gnt=%b wen=%b ren=%b addr=%h wdata=%h, expected gnt=1 wen=1 ren=0 addr=0010 wdata=deadbeef",
                     bus.core_gnt, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata);
        end
        ref_mem[8'h10] = 32'hDEADBEEF;
        tick();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (bus.mem_wen !== 1'b0 || bus.core_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done: got wen=%b gnt=%b, expected 0 0", bus.mem_wen, bus.core_gnt);
        end
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0020; bus.dbg_wdata = 32'h12345678;
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b1 || bus.core_gnt !== 1'b0 || bus.mem_wen !== 1'b1 ||
            bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL dbg_write: got gnt=%b wen=%b addr=%h wdata=%h, expected gnt=1 wen=1 addr=0020 wdata=12345678",
                     bus.dbg_gnt, bus.mem_wen, bus.mem_addr, bus.mem_wdata);
        end
        ref_mem[8'h20] = 32'h12345678;
        tick();
        clear_reqs();
        $display("write transactions done");
    endtask

    task automatic test_read();
        tick();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 16'h0010;
        @(negedge clk);
        vectors++;
        if (bus.core_gnt !== 1'b1 || bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL core_read_gnt: got gnt=%b ren=%b wen=%b addr=%h, expected 1 1 0 0010",
                     bus.core_gnt, bus.mem_ren, bus.mem_wen, bus.mem_addr);
        end
        sb.push_back('{REQ_CORE, ref_mem[8'h10], cycle});
        tick();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (bus.core_gnt !== 1'b0 || bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL rdata_quiet: got gnt=%b ren=%b wen=%b, expected 0 0 0",
                     bus.core_gnt, bus.mem_ren, bus.mem_wen);
        end
        tick();
    endtask

    task automatic test_simul_reads();
        apply_reset();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 16'h0010;
        bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b0; bus.dbg_addr  = 16'h0020;
        @(negedge clk);
        vectors++;
        if (bus.core_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_first: got core_gnt=%b dbg_gnt=%b, expected 1 0", bus.core_gnt, bus.dbg_gnt);
        end
        sb.push_back('{REQ_CORE, ref_mem[8'h10], cycle});
        tick();
        bus.core_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_wait: got dbg_gnt=%b, expected 0", bus.dbg_gnt);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b1 || bus.mem_ren !== 1'b1 || bus.mem_addr !== 16'h0020) begin
            miscompares++;
            $display("FAIL simul_second: got dbg_gnt=%b ren=%b addr=%h, expected 1 1 0020",
                     bus.dbg_gnt, bus.mem_ren, bus.mem_addr);
        end
        sb.push_back('{REQ_DBG, ref_mem[8'h20], cycle});
        tick();
        clear_reqs();
        tick();
    endtask

    task automatic test_back_to_back();
        int ck = 0;
        int dk = 0;
        int exp_core;
        int exp_dbg;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            logic exp_is_core;
            bus.core_req = 1'b1; bus.core_we = 1'b1;
            bus.core_addr = 16'h0040 + 16'(ck); bus.core_wdata = 32'hC0DE0000 | 32'(ck);
            bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b1;
            bus.dbg_addr  = 16'h0080 + 16'(dk); bus.dbg_wdata  = 32'hDB600000 | 32'(dk);
`ifdef MEM_ARB_RR_EN
            exp_is_core = (k % 2 == 0);
`else
            exp_is_core = 1'b1;
`endif
            @(negedge clk);
            vectors++;
            if (bus.core_gnt !== exp_is_core || bus.dbg_gnt !== !exp_is_core || bus.mem_wen !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: got core_gnt=%b dbg_gnt=%b wen=%b, expected %b %b 1",
                         k, bus.core_gnt, bus.dbg_gnt, bus.mem_wen, exp_is_core, !exp_is_core);
            end else begin
                $display("b2b write %0d granted to %s addr=%h", k, bus.core_gnt ? "core" : "dbg", bus.mem_addr);
            end
            if (bus.core_gnt) begin
                ref_mem[bus.core_addr[7:0]] = bus.core_wdata;
                ck++;
            end else if (bus.dbg_gnt) begin
                ref_mem[bus.dbg_addr[7:0]] = bus.dbg_wdata;
                dk++;
            end
            tick();
        end
        clear_reqs();
`ifdef MEM_ARB_RR_EN
        exp_core = 4; exp_dbg = 4;
`else
        exp_core = 8; exp_dbg = 0;
`endif
        vectors++;
        if (ck != exp_core || dk != exp_dbg) begin
            miscompares++;
            $display("FAIL b2b_counts: got core=%0d dbg=%0d, expected %0d %0d", ck, dk, exp_core, exp_dbg);
        end
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0042;
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL readback_gnt: got dbg_gnt=%b, expected 1", bus.dbg_gnt);
        end
        sb.push_back('{REQ_DBG, ref_mem[8'h42], cycle});
        tick();
        clear_reqs();
        tick();
    endtask

    task automatic test_reset_in_rdata();
        apply_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0020;
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rd_gnt: got dbg_gnt=%b, expected 1", bus.dbg_gnt);
        end
        tick();
        clear_reqs();
        vectors++;
        if (bus.dbg_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rd_pre: got dbg_rvalid=%b, expected 1", bus.dbg_rvalid);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_rd_drop: got dbg_rvalid=%b dbg_rdata=%h, expected 0 0", bus.dbg_rvalid, bus.dbg_rdata);
        end
        tick();
        rst = 1'b1;
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 16'h0050; bus.core_wdata = 32'hAAAA5555;
        bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b1; bus.dbg_addr  = 16'h0051; bus.dbg_wdata  = 32'h5555AAAA;
        @(negedge clk);
        vectors++;
        if (bus.core_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_first_arb: got core_gnt=%b dbg_gnt=%b, expected 1 0", bus.core_gnt, bus.dbg_gnt);
        end
        ref_mem[8'h50] = 32'hAAAA5555;
        tick();
        clear_reqs();
        tick();
    endtask

    task automatic test_req_in_rdata();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 16'h0050;
        @(negedge clk);
        vectors++;
        if (bus.core_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rdq_core_gnt: got core_gnt=%b, expected 1", bus.core_gnt);
        end
        sb.push_back('{REQ_CORE, ref_mem[8'h50], cycle});
        tick();
        clear_reqs();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0010;
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b0 || bus.mem_ren !== 1'b0) begin
            miscompares++;
            $display("FAIL rdq_blocked: got dbg_gnt=%b ren=%b, expected 0 0", bus.dbg_gnt, bus.mem_ren);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (bus.dbg_gnt !== 1'b1 || bus.mem_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL rdq_late_gnt: got dbg_gnt=%b addr=%h, expected 1 0010", bus.dbg_gnt, bus.mem_addr);
        end
        sb.push_back('{REQ_DBG, ref_mem[8'h10], cycle});
        tick();
        clear_reqs();
        repeat (2) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        clear_reqs();
        test_reset();
        test_write();
        test_read();
        test_simul_reads();
        test_back_to_back();
        test_reset_in_rdata();
        test_req_in_rdata();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_rvalid: got %0d outstanding reads, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-ported unified memory (`NextMemory`) in the multicycle core. It lets the core's fetch/load-store port and a debug/boot-loader port share that memory. It serialises accesses, drives the memory's `wen`/`ren`/address/write-data, and routes the one-cycle-latency read data back to the requester that issued the read. It sits between the core's `mem_addr`/`mem_wdata` path and the memory instance.

## Interface
- `ADDR_W`, 16: word address width (byte address bits [17:2])
- `DATA_W`, 32: data width
- `clk`  input  1  system clock
- `rst`  input  1  asynchronous, active-low reset
- `core_req`  input  1  core access request; held with fields stable until `core_gnt`
- `core_we`  input  1  1 = write, 0 = read
- `core_addr`  input  ADDR_W  core word address
- `core_wdata`  input  DATA_W  core write data
- `core_gnt`  output  1  request accepted this cycle
- `core_rvalid`  output  1  read data valid for core
- `core_rdata`  output  DATA_W  read data; 0 when `core_rvalid`=0
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as `core_*`, for the debug port
- `mem_wen`  output  1  memory write enable
- `mem_ren`  output  1  memory read enable
- `mem_addr`  output  ADDR_W  memory word address
- `mem_wdata`  output  DATA_W  memory write data
- `mem_rdata`  input  DATA_W  memory read data, valid the cycle after `mem_ren`

## Operation
- FSM states:
  - IDLE: grant possible.
  - RDATA: read return cycle; no grant.
- IDLE with no request:
  - all `mem_*` enables 0.
  - `mem_addr` and `mem_wdata` 0.
- IDLE with at least one `*_req`:
  - Select a winner; assert its `*_gnt` combinationally this cycle.
  - Drive `mem_addr`/`mem_wdata` from the winner.
  - Winner `we`=1: `mem_wen`=1; stay in IDLE.
  - Winner `we`=0: `mem_ren`=1; latch owner id; go to RDATA.
- RDATA:
  - Assert owner's `*_rvalid`; owner's `*_rdata` = `mem_rdata`.
  - No `gnt`, no `mem_*` enables.
  - Return to IDLE next cycle.
- Default priority: fixed, core beats debug on a simultaneous request.
- A requester dropping `req` before `gnt` is legal and leaves no arbiter state behind.
- Non-owner `*_rvalid` is 0 and its `*_rdata` is 0.
- Reset (asynchronous, mid-operation included):
  - FSM returns to IDLE.
  - Owner is cleared; priority pointer points at core.
  - All `gnt`, `rvalid`, `mem_wen`, `mem_ren` are 0 immediately.
  - A read in flight is dropped; its `rvalid` is never produced.

## Timing
- Grant latency: 0 cycles from `req` when in IDLE; 1 extra cycle if the request arrives in RDATA.
- Write: completes at the clock edge ending the grant cycle.
- Back-to-back writes: one per cycle.
- Read: `rvalid` exactly 1 cycle after `gnt`.
- Back-to-back reads: one per 2 cycles.
- Combinational path `*_req` → `*_gnt`/`mem_*`; no combinational path from `mem_rdata` to any enable.
- Owner and state registers update on the rising edge of `clk`.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin: a 1-bit pointer names the preferred requester.
  - After each grant the pointer flips to the requester not granted.
  - Reset value of the pointer: core.
  - A lone requester is always granted regardless of the pointer.
- `MEM_ARB_RR_EN` undefined:
  - Fixed core priority; the pointer register is absent.
  - Debug may starve while the core requests continuously.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` {IDLE, RDATA}.
  - `req_id_e` {REQ_CORE, REQ_DBG}.
  - Localparams `ADDR_W_DEF`=16 and `DATA_W_DEF`=32.
- Sub-module `arb_pick`: combinational winner select from the two `req` bits and the pointer; outputs a one-hot grant. Only the pointer source differs between the two configurations.
- The FSM and owner register live in the top module.

## Test plan
- Core write `addr=0x0010`, `wdata=0xDEADBEEF`, `dbg_req`=0:
  - same cycle `core_gnt`=1, `mem_wen`=1, `mem_addr`=0x0010;
  - next cycle `mem_wen`=0.
- Core read `addr=0x0010`, memory returns `0xDEADBEEF`:
  - `core_gnt` in cycle N;
  - `core_rvalid`=1, `core_rdata`=0xDEADBEEF in N+1;
  - `dbg_rvalid`=0, `dbg_rdata`=0 throughout.
- Both request reads at the same time, RR disabled:
  - core granted in N, rvalid in N+1;
  - debug granted in N+2, rvalid in N+3.
- Both request continuously with `MEM_ARB_RR_EN`, 8 writes total:
  - grants alternate core, dbg, core, dbg, …;
  - 4 each.
- Reset asserted in RDATA after a debug read:
  - `dbg_rvalid` goes to 0 immediately;
  - after release, FSM is in IDLE;
  - first simultaneous request goes to core.
- `dbg_req` raised in RDATA of a core read:
  - no grant in that cycle;
  - `dbg_gnt`=1 in the following cycle.
